// File: rtl/codeword_tx.sv
// Serial codeword transmitter: sends a captured word MSB-first, repeated rep_in+1 times.
// Optional idle-filler LFSR enabled by defining FILLER_LFSR_EN; otherwise idle bit is 0.
module codeword_tx #(
   parameter int unsigned WORD_W    = 12,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] word_in,
   input  logic [3:0]        rep_in,
   output logic              serial_out,
   output logic              busy,
   output logic              frame_start,
   output logic              done,
   output logic [15:0]       sent_count
);

   localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(WORD_W - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [3:0]        rep_q, rep_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [BIT_W-1:0]  bit_dec_c;
   logic [15:0]       cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              frame_q, frame_d;
   logic              done_q, done_d;
   logic              serial_q, serial_d;
   logic              idle_nxt_c;
   logic              idle_rst_c;

`ifdef FILLER_LFSR_EN
   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0; frozen while sending.
   logic [15:0] lfsr_q, lfsr_d;
   logic        lfsr_fb_c;

   always_comb begin
      lfsr_fb_c = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      lfsr_d    = lfsr_q;
      if (state_q == IDLE) begin
         lfsr_d = {lfsr_fb_c, lfsr_q[15:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign idle_nxt_c = lfsr_d[0];
   assign idle_rst_c = LFSR_SEED[0];
`else
   logic unused_seed_c;

   assign unused_seed_c = ^LFSR_SEED;
   assign idle_nxt_c    = 1'b0;
   assign idle_rst_c    = 1'b0;
`endif

   assign bit_dec_c = bit_q - BIT_W'(1);

   // Next-state and next-output logic; outputs are registered one-to-one from *_d.
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      rep_d    = rep_q;
      bit_d    = bit_q;
      cnt_d    = cnt_q;
      busy_d   = 1'b0;
      frame_d  = 1'b0;
      done_d   = 1'b0;
      serial_d = idle_nxt_c;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SEND;
               word_d   = word_in;
               rep_d    = rep_in;
               bit_d    = MSB_IDX;
               busy_d   = 1'b1;
               frame_d  = 1'b1;
               serial_d = word_in[WORD_W-1];
            end
         end
         SEND: begin
            busy_d = 1'b1;
            if (bit_q != '0) begin
               bit_d    = bit_dec_c;
               serial_d = word_q[bit_dec_c];
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (rep_q != 4'd0) begin
                  // Next repetition starts immediately, no gap cycle.
                  rep_d    = rep_q - 4'd1;
                  bit_d    = MSB_IDX;
                  frame_d  = 1'b1;
                  serial_d = word_q[WORD_W-1];
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         word_q   <= '0;
         rep_q    <= '0;
         bit_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         frame_q  <= 1'b0;
         done_q   <= 1'b0;
         serial_q <= idle_rst_c;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         rep_q    <= rep_d;
         bit_q    <= bit_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         frame_q  <= frame_d;
         done_q   <= done_d;
         serial_q <= serial_d;
      end
   end

   assign serial_out  = serial_q;
   assign busy        = busy_q;
   assign frame_start = frame_q;
   assign done        = done_q;
   assign sent_count  = cnt_q;

endmodule

// File: tb/tb_codeword_tx.sv
// Directed, table-driven bench for codeword_tx (WORD_W=12).
module tb_codeword_tx;

   localparam int unsigned WORD_W = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [WORD_W-1:0] word_in;
   logic [3:0]        rep_in;
   logic              serial_out;
   logic              busy;
   logic              frame_start;
   logic              done;
   logic [15:0]       sent_count;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] cnt_m = 16'd0;

   typedef struct {
      logic [WORD_W-1:0] word;
      logic [3:0]        rep;
      int                len;
      bit                noise;
   } vec_t;

   vec_t vecs[6];

   codeword_tx #(.WORD_W(WORD_W), .LFSR_SEED(16'hACE1)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_in    (word_in),
      .rep_in     (rep_in),
      .serial_out (serial_out),
      .busy       (busy),
      .frame_start(frame_start),
      .done       (done),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   // Send one sequence from idle and check every busy cycle plus the done cycle.
   task automatic run_vec(input logic [WORD_W-1:0] w, input logic [3:0] r,
                          input int len, input bit noise);
      logic [15:0] c0;
      c0      = cnt_m;
      word_in = w;
      rep_in  = r;
      start   = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < len; k++) begin
         chk("busy", 32'(busy), 32'd1);
         chk("serial", 32'(serial_out), 32'(w[WORD_W-1-(k % WORD_W)]));
         chk("frame_start", 32'(frame_start), 32'((k % WORD_W) == 0));
         chk("done_in_busy", 32'(done), 32'd0);
         chk("count_mid", 32'(sent_count), 32'(c0 + 16'(k / WORD_W)));
         if (noise) begin
            start   = 1'b1;
            word_in = ~w;
            rep_in  = 4'hF;
         end
         step();
      end
      start = 1'b0;
      cnt_m = c0 + 16'(r) + 16'd1;
      chk("busy_fall", 32'(busy), 32'd0);
      chk("done_pulse", 32'(done), 32'd1);
      chk("frame_idle", 32'(frame_start), 32'd0);
      chk("count_end", 32'(sent_count), 32'(cnt_m));
`ifndef FILLER_LFSR_EN
      chk("idle_bit", 32'(serial_out), 32'd0);
`endif
      step();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("stay_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [15:0] lf;
      logic [WORD_W-1:0] wa;
      logic [WORD_W-1:0] wb;

      vecs[0] = '{word: 12'b101100000100, rep: 4'd0,  len: 12,  noise: 1'b0};
      vecs[1] = '{word: 12'hA5C,          rep: 4'd2,  len: 36,  noise: 1'b1};
      vecs[2] = '{word: 12'hFFF,          rep: 4'd0,  len: 12,  noise: 1'b1};
      vecs[3] = '{word: 12'h000,          rep: 4'd1,  len: 24,  noise: 1'b0};
      vecs[4] = '{word: 12'h801,          rep: 4'd15, len: 192, noise: 1'b0};
      vecs[5] = '{word: 12'h001,          rep: 4'd3,  len: 48,  noise: 1'b1};

      reset   = 1'b1;
      start   = 1'b0;
      word_in = '0;
      rep_in  = '0;
      step();
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame", 32'(frame_start), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(sent_count), 32'd0);
      reset = 1'b0;

      // Idle filler right after reset.
      lf = 16'hACE1;
      for (int i = 0; i < 8; i++) begin
`ifdef FILLER_LFSR_EN
         chk("idle_lfsr", 32'(serial_out), 32'(lf[0]));
`else
         chk("idle_zero", 32'(serial_out), 32'd0);
`endif
         chk("idle_busy", 32'(busy), 32'd0);
         lf = lfsr_next(lf);
         step();
      end

      for (int v = 0; v < 6; v++) begin
         run_vec(vecs[v].word, vecs[v].rep, vecs[v].len, vecs[v].noise);
      end

      // start held high: frames separated by exactly one done cycle; word change mid-frame ignored.
      wa      = 12'h3C5;
      wb      = 12'h9A6;
      word_in = wa;
      rep_in  = 4'd0;
      start   = 1'b1;
      step();
      for (int k = 0; k < 12; k++) begin
         chk("hold_a_busy", 32'(busy), 32'd1);
         chk("hold_a_bit", 32'(serial_out), 32'(wa[11-k]));
         if (k == 5) word_in = wb;
         step();
      end
      chk("hold_gap_busy", 32'(busy), 32'd0);
      chk("hold_gap_done", 32'(done), 32'd1);
      cnt_m = cnt_m + 16'd1;
      step();
      for (int k = 0; k < 12; k++) begin
         chk("hold_b_busy", 32'(busy), 32'd1);
         chk("hold_b_bit", 32'(serial_out), 32'(wb[11-k]));
         chk("hold_b_frame", 32'(frame_start), 32'(k == 0));
         if (k == 11) start = 1'b0;
         step();
      end
      cnt_m = cnt_m + 16'd1;
      chk("hold_end_done", 32'(done), 32'd1);
      chk("hold_count", 32'(sent_count), 32'(cnt_m));
      step();

      // Reset mid-frame with start on the same edge.
      word_in = 12'hF0F;
      rep_in  = 4'd3;
      start   = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 6; k++) step();
      reset = 1'b1;
      start = 1'b1;
      step();
      cnt_m = 16'd0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_frame", 32'(frame_start), 32'd0);
      chk("abort_count", 32'(sent_count), 32'd0);
`ifndef FILLER_LFSR_EN
      chk("abort_idle_bit", 32'(serial_out), 32'd0);
`endif
      reset = 1'b0;
      start = 1'b0;
      step();
      chk("abort_no_accept", 32'(busy), 32'd0);
      chk("abort_no_done", 32'(done), 32'd0);
      step();

      // Counter wrap via backdoor preload.
      force dut.cnt_q = 16'hFFFF;
      #1;
      release dut.cnt_q;
      cnt_m = 16'hFFFF;
      run_vec(12'h5A5, 4'd0, 12, 1'b0);
      chk("wrap_zero", 32'(sent_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/codeword_tx.md
CODEWORD_TX -- requirements
Module: codeword_tx

Interface
REQ-001 The block SHALL have parameter WORD_W, default 12, giving codeword width in bits.
REQ-002 The block SHALL have parameter LFSR_SEED, default 16'hACE1, giving the idle-filler LFSR reset value; it must be non-zero.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to transmit; sampled only while busy=0.
REQ-006 The block SHALL have port word_in  input  WORD_W  codeword to send; captured on an accepted start.
REQ-007 The block SHALL have port rep_in  input  4  repeat count; the word is sent rep_in+1 times back-to-back (1..16).
REQ-008 The block SHALL have port serial_out  output  1  serial bitstream, MSB-first, one bit per clk cycle.
REQ-009 The block SHALL have port busy  output  1  high while a frame sequence is in flight.
REQ-010 The block SHALL have port frame_start  output  1  one-cycle pulse coincident with the MSB of each repetition.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse in the first idle cycle after the final bit.
REQ-012 The block SHALL have port sent_count  output  16  number of completed repetitions since reset.

Function
REQ-013 The FSM SHALL have states IDLE and SEND; there is no other state.
REQ-014 In IDLE, start=1 at edge T SHALL capture word_in and rep_in, enter SEND, and drive busy=1, frame_start=1, serial_out=word_in[WORD_W-1] after edge T.
REQ-015 After edge T+k, for k=0..WORD_W-1, serial_out SHALL equal captured word bit WORD_W-1-k; each bit is held exactly one cycle.
REQ-016 At the edge that completes bit 0 with repetitions remaining, the block SHALL restart at the MSB with no gap cycle, pulse frame_start, and decrement the remaining-repeat counter.
REQ-017 At the edge that completes bit 0 of the final repetition, the block SHALL enter IDLE, drive busy=0 and done=1 for exactly one cycle, and output the idle bit.
REQ-018 sent_count SHALL increment by 1 at every edge completing bit 0 of any repetition, wrapping 16'hFFFF to 16'h0000.
REQ-019 start while busy=1, including in the done cycle's preceding edge, SHALL be ignored; word_in and rep_in are not re-sampled mid-sequence.
REQ-020 start=1 in the done cycle SHALL be accepted normally (back-to-back sequences separated by exactly one idle cycle).
REQ-021 Total sequence latency SHALL be (rep_in+1)*WORD_W cycles from the accepting edge to busy falling.

Reset
REQ-022 reset=1 at an edge SHALL force IDLE, busy=0, frame_start=0, done=0, sent_count=0, captured word=0, and the LFSR to LFSR_SEED; serial_out takes the idle bit of the reset state.
REQ-023 reset SHALL take priority over start on the same edge.
REQ-024 reset mid-SEND SHALL abort the frame with no done pulse and no sent_count increment.

Configuration
REQ-025 Macro FILLER_LFSR_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, shift toward bit 0, feedback into bit 15) SHALL advance one step each IDLE cycle, hold during SEND, and the idle bit SHALL be its bit 0.
REQ-026 Macro FILLER_LFSR_EN undefined: no LFSR is built, LFSR_SEED is unused, and the idle bit SHALL be constant 0.

Verification
REQ-027 Reset 2 cycles, start=1 one cycle with word_in=12'b101100000100, rep_in=0 -> serial_out 1,0,1,1,0,0,0,0,0,1,0,0 on the next 12 cycles; frame_start on cycle 1; done on cycle 13; sent_count=1.
REQ-028 word_in=12'hA5C, rep_in=2 -> 36 contiguous bits (A5C three times), frame_start at cycles 1, 13, 25; done at cycle 37; sent_count=3.
REQ-029 start held high continuously with rep_in=0 -> sequences of 12 busy cycles separated by exactly one idle (done) cycle; start pulses during busy do not change captured word.
REQ-030 reset asserted at bit 6 of a frame with start=1 on the same edge -> busy=0 next cycle, no done pulse, sent_count=0, start not accepted.
REQ-031 Force sent_count to 16'hFFFF via 65535 single sends (or backdoor), send one more -> sent_count=16'h0000.
REQ-032 With FILLER_LFSR_EN, idle after reset -> serial_out follows the LFSR bit-0 sequence from seed 16'hACE1 and freezes during SEND; without it -> serial_out=0 whenever busy=0.
